// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter and instruction-fetch front end.
//
// Issues in-order fetch requests from a PC register. At most two instructions
// may be in flight or buffered at once. Returned instructions are paired with
// their PC and are presented to decode through a 2-entry output FIFO. A
// redirect flushes the FIFO and arranges for every still-outstanding response
// to be discarded.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   redirect_valid, redirect_pc   redirect request and target
//   imem_req_valid/addr/ready     fetch request handshake (addr == PC)
//   imem_rsp_valid/data           in-order fetch response, no back-pressure
//   id_valid/pc/inst/ready        instruction handshake toward decode

`ifndef PC_BOOT_ADDR
`define PC_BOOT_ADDR 64'h0000_0000_8000_0000
`endif

module pc_fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = DATA_WIDTH'(`PC_BOOT_ADDR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [INST_WIDTH-1:0] id_inst,
    input  logic                  id_ready
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]            ost_q, ost_d;            // outstanding requests
    logic [1:0]            drop_q, drop_d;          // responses still to discard
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    // In-flight PC queue: PCs of issued requests awaiting their response.
    logic [DATA_WIDTH-1:0] ifq_q [2];
    logic [DATA_WIDTH-1:0] ifq_d [2];
    logic                  ifq_wr_q, ifq_wr_d, ifq_rd_q, ifq_rd_d;

    // Output FIFO toward decode.
    logic [DATA_WIDTH-1:0] fpc_q [2];
    logic [DATA_WIDTH-1:0] fpc_d [2];
    logic [INST_WIDTH-1:0] finst_q [2];
    logic [INST_WIDTH-1:0] finst_d [2];
    logic                  fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

    logic       id_fire, req_fire, rsp_fire, rsp_keep;
    logic [2:0] occupancy;
    logic       unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Outputs are gated by rst so nothing is presented while reset is sampled.
    assign id_valid = rst && (fifo_cnt_q != 2'd0);
    assign id_pc    = id_valid ? fpc_q[fifo_rd_q] : '0;
    assign id_inst  = id_valid ? finst_q[fifo_rd_q] : '0;
    assign id_fire  = id_valid && id_ready;

    // A same-cycle decode pop frees its slot immediately; this is what lets a
    // 1-cycle memory sustain one instruction per cycle without ever
    // overflowing the FIFO (in-flight + buffered never exceeds 2).
    assign occupancy      = {1'b0, ost_q} + {1'b0, fifo_cnt_q} - {2'b00, id_fire};
    assign imem_req_valid = rst && !redirect_valid && (occupancy < 3'd2);
    assign imem_req_addr  = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = imem_rsp_valid && (ost_q != 2'd0);
    assign rsp_keep = rsp_fire && (drop_q == 2'd0) && !redirect_valid;

    always_comb begin
        pc_d       = pc_q;
        ost_d      = ost_q + 2'(req_fire) - 2'(rsp_fire);
        drop_d     = drop_q;
        ifq_d      = ifq_q;
        ifq_wr_d   = ifq_wr_q;
        ifq_rd_d   = ifq_rd_q;
        fpc_d      = fpc_q;
        finst_d    = finst_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;

        if (redirect_valid) begin
            pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
        end else if (req_fire) begin
            pc_d = pc_q + DATA_WIDTH'(4);
        end

        if (req_fire) begin
            ifq_d[ifq_wr_q] = pc_q;
            ifq_wr_d        = ~ifq_wr_q;
        end
        if (rsp_fire) begin
            ifq_rd_d = ~ifq_rd_q;
        end

        // Everything still outstanding after a redirect belongs to the old path.
        if (redirect_valid) begin
            drop_d = ost_q - 2'(rsp_fire);
        end else if (rsp_fire && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
        end

        if (redirect_valid) begin
            fifo_cnt_d = 2'd0;
            fifo_rd_d  = fifo_wr_q;
        end else begin
            if (rsp_keep) begin
                fpc_d[fifo_wr_q]   = ifq_q[ifq_rd_q];
                finst_d[fifo_wr_q] = imem_rsp_data;
                fifo_wr_d          = ~fifo_wr_q;
            end
            if (id_fire) begin
                fifo_rd_d = ~fifo_rd_q;
            end
            fifo_cnt_d = fifo_cnt_q + 2'(rsp_keep) - 2'(id_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= BOOT_ADDR;
            ost_q      <= 2'd0;
            drop_q     <= 2'd0;
            fifo_cnt_q <= 2'd0;
            ifq_wr_q   <= 1'b0;
            ifq_rd_q   <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ost_q      <= ost_d;
            drop_q     <= drop_d;
            fifo_cnt_q <= fifo_cnt_d;
            ifq_wr_q   <= ifq_wr_d;
            ifq_rd_q   <= ifq_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
        end
    end

    // Storage only; validity is tracked by the counters above.
    always_ff @(posedge clk) begin
        ifq_q   <= ifq_d;
        fpc_q   <= fpc_d;
        finst_q <= finst_d;
    end

endmodule
